// File: rtl/rob_field_queue.sv
// Circular-queue storage for one reorder-buffer field with per-entry done bits,
// multi-port writeback, full flush and partial rollback of younger entries.
module rob_field_queue #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned IDX_W   = $clog2(DEPTH),
    parameter int unsigned NUM_UPD = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue,
    input  logic [WIDTH-1:0]           datain_issue,
    input  logic                       issue_done,
    output logic [IDX_W-1:0]           issue_idx,
    input  logic [NUM_UPD-1:0]         update,
    input  logic [NUM_UPD*IDX_W-1:0]   update_index,
    input  logic [NUM_UPD*WIDTH-1:0]   datain_update,
    input  logic                       commit,
    output logic [WIDTH-1:0]           dataout,
    output logic [IDX_W-1:0]           commit_ptr_rob_idx,
    output logic                       commit_ready,
    input  logic                       flush,
    input  logic                       rollback,
    input  logic [IDX_W-1:0]           rollback_idx,
    output logic                       cir_q_empty,
    output logic                       cir_q_full,
    output logic [IDX_W:0]             count
);

    localparam int unsigned PW = IDX_W + 1;

    logic [PW-1:0]      head, tail;
    logic [DEPTH-1:0]   valid, done;
    logic [WIDTH-1:0]   data [DEPTH];

    logic [IDX_W-1:0]   head_idx, tail_idx, rb_off;
    logic [PW-1:0]      rb_tail;
    logic               do_issue, do_commit;
    logic [DEPTH-1:0]   squash;
    logic [IDX_W-1:0]   upd_idx [NUM_UPD];
    logic [WIDTH-1:0]   upd_dat [NUM_UPD];
    logic [NUM_UPD-1:0] upd_ok;

    assign head_idx           = head[IDX_W-1:0];
    assign tail_idx           = tail[IDX_W-1:0];
    assign cir_q_empty        = (head == tail);
    assign cir_q_full         = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
    assign count              = tail - head;
    assign commit_ready       = !cir_q_empty && done[head_idx];
    assign dataout            = data[head_idx];
    assign commit_ptr_rob_idx = head_idx;
    assign issue_idx          = tail_idx;

    assign do_issue  = issue && !cir_q_full && !rollback;
    assign do_commit = commit && commit_ready;

    // Rollback measured as an offset from head, so the new tail inherits the right wrap bit.
    assign rb_off  = rollback_idx - head_idx;
    assign rb_tail = head + PW'(rb_off) + PW'(1);

    // Entries older-than-tail but younger than rollback_idx are squashed.
    always_comb begin
        squash = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            squash[i] = rollback
                && (PW'(IDX_W'(IDX_W'(i) - head_idx)) > PW'(rb_off))
                && (PW'(IDX_W'(IDX_W'(i) - head_idx)) < count);
        end
    end

    // Writeback qualification: live entry, not squashed, not retiring, not the issuing slot.
    always_comb begin
        upd_ok = '0;
        for (int p = 0; p < int'(NUM_UPD); p++) begin
            upd_idx[p] = update_index[p*IDX_W +: IDX_W];
            upd_dat[p] = datain_update[p*WIDTH +: WIDTH];
            upd_ok[p]  = update[p] && valid[upd_idx[p]] && !squash[upd_idx[p]]
                && !(do_commit && (upd_idx[p] == head_idx))
                && !(do_issue && (upd_idx[p] == tail_idx));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            // Ascending port order: the highest-numbered port's data lands last.
            for (int p = 0; p < int'(NUM_UPD); p++) begin
                if (upd_ok[p]) begin
                    data[upd_idx[p]] <= upd_dat[p];
                    done[upd_idx[p]] <= 1'b1;
                end
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (squash[i]) begin
                    valid[i] <= 1'b0;
                    done[i]  <= 1'b0;
                end
            end
            if (do_commit) begin
                valid[head_idx] <= 1'b0;
                done[head_idx]  <= 1'b0;
                head            <= head + PW'(1);
            end
            if (do_issue) begin
                data[tail_idx]  <= datain_issue;
                done[tail_idx]  <= issue_done;
                valid[tail_idx] <= 1'b1;
            end
            if (rollback) begin
                tail <= rb_tail;
            end else if (do_issue) begin
                tail <= tail + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rob_field_queue.sv
// Bench for rob_field_queue (DEPTH=4): directed vector table, async-reset check,
// then random traffic against an ordered-queue reference model.
module tb_rob_field_queue;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue, idone, commit, flush, rollback;
    logic [31:0]   din;
    logic [6:0]    upd;
    logic [13:0]   uidx;
    logic [223:0]  udat;
    logic [1:0]    rbi;
    logic [1:0]    issue_idx, cptr;
    logic [31:0]   dataout;
    logic          crdy, emp, ful;
    logic [2:0]    cnt;

    int n_cmp = 0;
    int n_bad = 0;

    rob_field_queue #(.WIDTH(32), .DEPTH(4), .NUM_UPD(7)) dut (
        .clk(clk), .rst(rst), .issue(issue), .datain_issue(din), .issue_done(idone),
        .issue_idx(issue_idx), .update(upd), .update_index(uidx), .datain_update(udat),
        .commit(commit), .dataout(dataout), .commit_ptr_rob_idx(cptr),
        .commit_ready(crdy), .flush(flush), .rollback(rollback), .rollback_idx(rbi),
        .cir_q_empty(emp), .cir_q_full(ful), .count(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iss;
        logic [31:0] din;
        logic        idn;
        logic [6:0]  upd;
        logic [13:0] uidx;
        logic [223:0] udat;
        logic        cmt, fl, rb;
        logic [1:0]  rbi;
        logic [2:0]  e_cnt;
        logic        e_emp, e_ful, e_crdy;
        logic [1:0]  e_hd, e_tl;
        logic [31:0] e_dout;
    } vec_t;

    vec_t tbl[$];

    // reference model: ordered done bits oldest-first, head index, shadow storage
    bit          mq[$];
    int          mh;
    logic [31:0] mdata [4];
    int          rb_k;

    task automatic chk(input string nm, input int id, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", nm, id, a, e);
        end
    endtask

    task automatic chk_all(input string tag, input int id, input logic [2:0] e_cnt,
                           input logic e_emp, input logic e_ful, input logic e_crdy,
                           input logic [1:0] e_hd, input logic [1:0] e_tl,
                           input logic [31:0] e_dout);
        chk({tag, " count"}, id, 32'(cnt), 32'(e_cnt));
        chk({tag, " empty"}, id, 32'(emp), 32'(e_emp));
        chk({tag, " full"}, id, 32'(ful), 32'(e_ful));
        chk({tag, " commit_ready"}, id, 32'(crdy), 32'(e_crdy));
        chk({tag, " head"}, id, 32'(cptr), 32'(e_hd));
        chk({tag, " issue_idx"}, id, 32'(issue_idx), 32'(e_tl));
        chk({tag, " dataout"}, id, dataout, e_dout);
    endtask

    function automatic logic [223:0] ud(input int p, input logic [31:0] d);
        logic [223:0] r;
        r = '0;
        r[p*32 +: 32] = d;
        return r;
    endfunction

    function automatic logic [13:0] ui(input int p, input logic [1:0] i);
        logic [13:0] r;
        r = '0;
        r[p*2 +: 2] = i;
        return r;
    endfunction

    task automatic add(input logic iss, input logic [31:0] d, input logic idn,
                       input logic [6:0] u, input logic [13:0] uix, input logic [223:0] udt,
                       input logic cm, input logic fl, input logic rb, input logic [1:0] rix,
                       input logic [2:0] e_cnt, input logic e_emp, input logic e_ful,
                       input logic e_crdy, input logic [1:0] e_hd, input logic [1:0] e_tl,
                       input logic [31:0] e_dout);
        vec_t v;
        v.iss = iss; v.din = d; v.idn = idn; v.upd = u; v.uidx = uix; v.udat = udt;
        v.cmt = cm; v.fl = fl; v.rb = rb; v.rbi = rix;
        v.e_cnt = e_cnt; v.e_emp = e_emp; v.e_ful = e_ful; v.e_crdy = e_crdy;
        v.e_hd = e_hd; v.e_tl = e_tl; v.e_dout = e_dout;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        issue = 0; din = '0; idone = 0; upd = '0; uidx = '0; udat = '0;
        commit = 0; flush = 0; rollback = 0; rbi = '0;
    endtask

    task automatic model_step();
        int  sz = mq.size();
        int  hi = mh % 4;
        int  ti = (mh + sz) % 4;
        bit  cr = (sz > 0) && mq[0];
        bit  doi, doc;
        if (flush) begin
            mq.delete();
            mh = 0;
        end else begin
            doi = issue && (sz < 4) && !rollback;
            doc = commit && cr;
            for (int p = 0; p < 7; p++) begin
                if (upd[p]) begin
                    int ix = int'(uidx[p*2 +: 2]);
                    int k  = (ix - hi + 4) % 4;
                    if (k < sz && !(doc && k == 0) && !(rollback && k > rb_k)) begin
                        mdata[ix] = udat[p*32 +: 32];
                        mq[k] = 1'b1;
                    end
                end
            end
            if (rollback) begin
                while (mq.size() > rb_k + 1) void'(mq.pop_back());
            end
            if (doc) begin
                void'(mq.pop_front());
                mh = (mh + 1) % 4;
            end
            if (doi) begin
                mdata[ti] = din;
                mq.push_back(idone);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #11;
        chk_all("reset", 0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
        #1 rst = 1'b1;

        //   iss din       idn upd         uidx                      udat                                      cm fl rb rbi  cnt emp ful rdy hd tl dout
        add(1, 32'h11, 0, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd1,0,0,0,2'd0,2'd1,32'h11);
        add(1, 32'h22, 0, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd2,0,0,0,2'd0,2'd2,32'h11);
        add(1, 32'h33, 0, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd3,0,0,0,2'd0,2'd3,32'h11);
        add(1, 32'h44, 0, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd4,0,1,0,2'd0,2'd0,32'h11);
        add(1, 32'h55, 0, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd4,0,1,0,2'd0,2'd0,32'h11);
        add(0, 32'h0, 0, 7'b1100100, ui(6,2'd0) | ui(5,2'd1) | ui(2,2'd1),
            ud(6,32'hAA) | ud(5,32'hB5) | ud(2,32'hB2), 0,0,0,2'd0, 3'd4,0,1,1,2'd0,2'd0,32'hAA);
        add(0, 32'h0, 0, 7'h00, 14'h0, 224'h0, 1,0,0,2'd0, 3'd3,0,0,1,2'd1,2'd0,32'hB5);
        add(1, 32'h66, 0, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd4,0,1,1,2'd1,2'd1,32'hB5);
        add(1, 32'h99, 1, 7'h00, 14'h0, 224'h0, 1,0,0,2'd0, 3'd3,0,0,0,2'd2,2'd1,32'h33);
        add(0, 32'h0, 0, 7'h01, ui(0,2'd2), ud(0,32'h3C), 0,0,0,2'd0, 3'd3,0,0,1,2'd2,2'd1,32'h3C);
        add(1, 32'h88, 1, 7'h00, 14'h0, 224'h0, 1,0,0,2'd0, 3'd3,0,0,0,2'd3,2'd2,32'h44);
        add(1, 32'h12, 1, 7'h08, ui(3,2'd3), ud(3,32'h123), 1,1,0,2'd0, 3'd0,1,0,0,2'd0,2'd0,32'h66);
        add(0, 32'h0, 0, 7'h01, ui(0,2'd3), ud(0,32'hDEAD), 0,0,0,2'd0, 3'd0,1,0,0,2'd0,2'd0,32'h66);
        add(0, 32'h0, 0, 7'h00, 14'h0, 224'h0, 1,0,0,2'd0, 3'd0,1,0,0,2'd0,2'd0,32'h66);
        add(1, 32'hA0, 0, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd1,0,0,0,2'd0,2'd1,32'hA0);
        add(1, 32'hA1, 0, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd2,0,0,0,2'd0,2'd2,32'hA0);
        add(1, 32'hA2, 0, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd3,0,0,0,2'd0,2'd3,32'hA0);
        add(1, 32'hA3, 0, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd4,0,1,0,2'd0,2'd0,32'hA0);
        add(1, 32'hBAD, 1, 7'h00, 14'h0, 224'h0, 0,0,1,2'd1, 3'd2,0,0,0,2'd0,2'd2,32'hA0);
        add(0, 32'h0, 0, 7'h02, ui(1,2'd3), ud(1,32'hEE), 0,0,0,2'd0, 3'd2,0,0,0,2'd0,2'd2,32'hA0);
        add(1, 32'h77, 0, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd3,0,0,0,2'd0,2'd3,32'hA0);
        add(0, 32'h0, 0, 7'h10, ui(4,2'd0), ud(4,32'hC0), 0,0,0,2'd0, 3'd3,0,0,1,2'd0,2'd3,32'hC0);
        add(1, 32'h78, 1, 7'h00, 14'h0, 224'h0, 1,0,0,2'd0, 3'd3,0,0,0,2'd1,2'd0,32'hA1);
        add(0, 32'h0, 0, 7'h01, ui(0,2'd1), ud(0,32'hD1), 0,0,0,2'd0, 3'd3,0,0,1,2'd1,2'd0,32'hD1);
        add(0, 32'h0, 0, 7'h00, 14'h0, 224'h0, 1,0,0,2'd0, 3'd2,0,0,0,2'd2,2'd0,32'h77);
        add(0, 32'h0, 0, 7'h40, ui(6,2'd2), ud(6,32'hF2), 0,0,0,2'd0, 3'd2,0,0,1,2'd2,2'd0,32'hF2);
        add(0, 32'h0, 0, 7'h00, 14'h0, 224'h0, 1,0,1,2'd2, 3'd0,1,0,0,2'd3,2'd3,32'h78);
        add(1, 32'h79, 1, 7'h00, 14'h0, 224'h0, 0,0,0,2'd0, 3'd1,0,0,1,2'd3,2'd0,32'h79);

        foreach (tbl[i]) begin
            issue = tbl[i].iss; din = tbl[i].din; idone = tbl[i].idn;
            upd = tbl[i].upd; uidx = tbl[i].uidx; udat = tbl[i].udat;
            commit = tbl[i].cmt; flush = tbl[i].fl; rollback = tbl[i].rb; rbi = tbl[i].rbi;
            @(posedge clk); #1;
            chk_all("vec", i, tbl[i].e_cnt, tbl[i].e_emp, tbl[i].e_ful, tbl[i].e_crdy,
                    tbl[i].e_hd, tbl[i].e_tl, tbl[i].e_dout);
        end
        idle_inputs();

        // asynchronous reset between clock edges with a ready, non-empty queue
        rst = 1'b0;
        #2;
        chk_all("async_rst", 0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
        #1 rst = 1'b1;

        mq.delete();
        mh = 0;
        for (int i = 0; i < 4; i++) mdata[i] = '0;

        for (int c = 0; c < 3000; c++) begin
            issue    = 1'($urandom_range(0, 1));
            din      = $urandom;
            idone    = 1'($urandom_range(0, 1));
            commit   = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 63) == 0);
            rollback = 1'b0;
            rbi      = 2'($urandom_range(0, 3));
            rb_k     = 0;
            if (mq.size() > 0 && $urandom_range(0, 7) == 0) begin
                rollback = 1'b1;
                rb_k     = int'($urandom_range(0, mq.size() - 1));
                rbi      = 2'((mh + rb_k) % 4);
            end
            for (int p = 0; p < 7; p++) begin
                upd[p]           = ($urandom_range(0, 3) == 0);
                uidx[p*2 +: 2]   = 2'($urandom_range(0, 3));
                udat[p*32 +: 32] = $urandom;
            end
            model_step();
            @(posedge clk); #1;
            chk_all("rnd", c, 3'(mq.size()), mq.size() == 0, mq.size() == 4,
                    (mq.size() > 0) && mq[0], 2'(mh % 4), 2'((mh + mq.size()) % 4),
                    mdata[mh % 4]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
